// File: rtl/lsu_dmem_agent_if.sv
// Shared packet types for the LSU/DMEM/CDB paths and the bundled handshake interface
// used by lsu_dmem_agent.
package lsu_dmem_agent_pkg;

    localparam int unsigned TAG_WIDTH = 6;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef struct packed {
        logic [31:0] data;
    } operand_t;

    typedef struct packed {
        logic                 is_valid;
        logic [6:0]           opcode;
        logic [7:0]           uop_0;
        operand_t             src_0_a;
        operand_t             src_1_b;
        logic [TAG_WIDTH-1:0] dest_tag;
    } instruction_t;

    typedef struct packed {
        logic                 is_valid;
        logic [31:0]          result;
        logic [TAG_WIDTH-1:0] dest_tag;
    } writeback_packet_t;

endpackage

interface lsu_dmem_agent_if;
    import lsu_dmem_agent_pkg::*;

    logic              lsu_req_rdy;
    instruction_t      lsu_req_packet;
    logic              dmem_req_rdy;
    instruction_t      dmem_req_packet;
    logic              dmem_rec_rdy;
    writeback_packet_t dmem_rec_packet;
    logic              cdb_rdy;
    writeback_packet_t cdb_packet;

    // master is the agent; slave is the surrounding LSU / memory / CDB environment.
    modport master (
        output lsu_req_rdy,
        input  lsu_req_packet,
        input  dmem_req_rdy,
        output dmem_req_packet,
        output dmem_rec_rdy,
        input  dmem_rec_packet,
        input  cdb_rdy,
        output cdb_packet
    );

    modport slave (
        input  lsu_req_rdy,
        output lsu_req_packet,
        output dmem_req_rdy,
        input  dmem_req_packet,
        input  dmem_rec_rdy,
        output dmem_rec_packet,
        output cdb_rdy,
        input  cdb_packet
    );

endinterface

// File: rtl/lsu_dmem_agent.sv
// DMEM initiator: buffers LSU requests onto DMEM, tracks outstanding loads, forwards load
// results in order to the CDB, rejects misaligned accesses and drains stale responses on flush.
module lsu_dmem_agent
    import lsu_dmem_agent_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    lsu_dmem_agent_if.master     bus,
    output logic                 misalign_val,
    output logic [TAG_WIDTH-1:0] misalign_tag,
    output logic                 idle
);

    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {StIdle, StBusy, StDrain} state_e;

    state_e            state_q, state_d;
    instruction_t      req_q, req_d;
    writeback_packet_t out_q, out_d;
    logic [CntW-1:0]   out_cnt_q, out_cnt_d;
    logic [CntW-1:0]   drop_cnt_q, drop_cnt_d;
    logic              misalign_val_d;
    logic [TAG_WIDTH-1:0] misalign_tag_d;

    logic            in_load, misaligned, req_has_load, load_ok;
    logic            req_fire, load_issue, accept, enter_req;
    logic            rec_fire, rec_to_drop, rec_to_out, out_load, cdb_fire;
    logic [2:0]      f3;
    logic [1:0]      addr_lo;
    logic [CntW:0]   inflight;

    assign f3         = bus.lsu_req_packet.uop_0[2:0];
    assign addr_lo    = bus.lsu_req_packet.src_0_a.data[1:0];
    assign in_load    = bus.lsu_req_packet.opcode == OPC_LOAD;
    assign misaligned = (((f3 == F3_H) || (f3 == F3_HU)) && addr_lo[0]) ||
                        ((f3 == F3_W) && (addr_lo != 2'b00));

    assign req_has_load = req_q.is_valid && (req_q.opcode == OPC_LOAD);
    assign req_fire     = req_q.is_valid && bus.dmem_req_rdy;
    assign load_issue   = req_fire && (req_q.opcode == OPC_LOAD);

    // A load still sitting in REQ already holds an outstanding slot.
    assign inflight = {1'b0, out_cnt_q} + {{CntW{1'b0}}, req_has_load};
    assign load_ok  = inflight < (CntW + 1)'(MAX_OUTSTANDING);

    assign bus.lsu_req_rdy = !rst && (state_q != StDrain) && !flush &&
                             (!req_q.is_valid || req_fire) && (!in_load || load_ok);
    assign accept          = bus.lsu_req_packet.is_valid && bus.lsu_req_rdy;
    assign enter_req       = accept && !misaligned;

    assign bus.dmem_rec_rdy = (state_q == StDrain) || !out_q.is_valid || bus.cdb_rdy;
    assign rec_fire         = bus.dmem_rec_packet.is_valid && bus.dmem_rec_rdy;
    // Stale responses are always older than live ones, so they are retired first.
    assign rec_to_drop      = rec_fire && (drop_cnt_q != '0);
    assign rec_to_out       = rec_fire && (drop_cnt_q == '0) && (out_cnt_q != '0);
    assign out_load         = rec_fire && !rec_to_drop && (state_q != StDrain) && !flush;
    assign cdb_fire         = out_q.is_valid && bus.cdb_rdy;

    assign bus.dmem_req_packet = req_q;
    assign bus.cdb_packet      = out_q;

    assign idle = (state_q == StIdle) && !req_q.is_valid && !out_q.is_valid &&
                  (out_cnt_q == '0) && (drop_cnt_q == '0);

    always_comb begin
        out_cnt_d      = out_cnt_q;
        drop_cnt_d     = drop_cnt_q;
        req_d          = req_q;
        out_d          = out_q;
        state_d        = state_q;
        misalign_val_d = accept && misaligned;
        misalign_tag_d = (accept && misaligned) ? bus.lsu_req_packet.dest_tag : '0;

        if (load_issue) out_cnt_d = out_cnt_d + CntW'(1);
        if (rec_to_out) out_cnt_d = out_cnt_d - CntW'(1);
        if (rec_to_drop) drop_cnt_d = drop_cnt_d - CntW'(1);

        if (enter_req) begin
            req_d = bus.lsu_req_packet;
        end else if (req_fire) begin
            req_d.is_valid = 1'b0;
        end

        if (out_load) begin
            out_d = bus.dmem_rec_packet;
        end else if (cdb_fire) begin
            out_d.is_valid = 1'b0;
        end

        if (flush) begin
            drop_cnt_d     = drop_cnt_d + out_cnt_d;
            out_cnt_d      = '0;
            req_d.is_valid = 1'b0;
            out_d.is_valid = 1'b0;
            state_d        = (drop_cnt_d != '0) ? StDrain : StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) state_d = StBusy;
                end
                StBusy: begin
                    if (!req_d.is_valid && (out_cnt_d == '0) && !out_d.is_valid) begin
                        state_d = StIdle;
                    end
                end
                StDrain: begin
                    if (drop_cnt_d == '0) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            req_q        <= '0;
            out_q        <= '0;
            out_cnt_q    <= '0;
            drop_cnt_q   <= '0;
            misalign_val <= 1'b0;
            misalign_tag <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            out_q        <= out_d;
            out_cnt_q    <= out_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            misalign_val <= misalign_val_d;
            misalign_tag <= misalign_tag_d;
        end
    end

endmodule

// File: tb/tb_lsu_dmem_agent.sv
// Directed bench for lsu_dmem_agent: a byte-array memory responder answers DMEM requests in
// order, and a scoreboard of expected CDB writebacks is checked as results leave the block.
module tb_lsu_dmem_agent;
    import lsu_dmem_agent_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic                 misalign_val;
    logic [TAG_WIDTH-1:0] misalign_tag;
    logic                 idle;

    lsu_dmem_agent_if bus ();

    lsu_dmem_agent #(
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .bus         (bus),
        .misalign_val(misalign_val),
        .misalign_tag(misalign_tag),
        .idle        (idle)
    );

    always #5 clk = ~clk;

    logic [7:0]        mem [64];
    writeback_packet_t resp_q [$];
    writeback_packet_t exp_q  [$];
    bit                resp_en;
    bit                lsu_acc;
    bit                req_seen;
    int                cdb_cnt;
    int                n_vec;
    int                n_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mem_access(input instruction_t p);
        logic [5:0]        a;
        logic [31:0]       w;
        writeback_packet_t r;
        a = p.src_0_a.data[5:0];
        if (p.opcode == OPC_STORE) begin
            mem[a] = p.src_1_b.data[7:0];
            if (p.uop_0[1:0] != 2'b00) mem[a + 6'd1] = p.src_1_b.data[15:8];
            if (p.uop_0[1:0] == 2'b10) begin
                mem[a + 6'd2] = p.src_1_b.data[23:16];
                mem[a + 6'd3] = p.src_1_b.data[31:24];
            end
        end else begin
            w = {mem[a + 6'd3], mem[a + 6'd2], mem[a + 6'd1], mem[a]};
            case (p.uop_0[2:0])
                3'b000:  w = {{24{w[7]}}, w[7:0]};
                3'b001:  w = {{16{w[15]}}, w[15:0]};
                3'b100:  w = {24'h0, w[7:0]};
                3'b101:  w = {16'h0, w[15:0]};
                default: ;
            endcase
            r.is_valid = 1'b1;
            r.result   = w;
            r.dest_tag = p.dest_tag;
            resp_q.push_back(r);
        end
    endtask

    // One clock: sample just before the posedge, then re-drive the responder after the negedge.
    task automatic tick();
        writeback_packet_t e;
        #4;
        lsu_acc = bus.lsu_req_packet.is_valid && bus.lsu_req_rdy;
        if (bus.dmem_req_packet.is_valid) req_seen = 1'b1;
        if (bus.dmem_req_packet.is_valid && bus.dmem_req_rdy) mem_access(bus.dmem_req_packet);
        if (bus.dmem_rec_packet.is_valid && bus.dmem_rec_rdy) void'(resp_q.pop_front());
        if (bus.cdb_packet.is_valid && bus.cdb_rdy) begin
            cdb_cnt++;
            if (exp_q.size() == 0) begin
                check("cdb_spurious", 32'(bus.cdb_packet.is_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("cdb_result", bus.cdb_packet.result, e.result);
                check("cdb_tag", 32'(bus.cdb_packet.dest_tag), 32'(e.dest_tag));
            end
        end
        @(negedge clk);
        bus.dmem_rec_packet = (resp_en && resp_q.size() != 0) ? resp_q[0] : '0;
    endtask

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input logic [5:0] tag, input bit exp_cdb,
                         input logic [31:0] exp_res);
        instruction_t      p;
        writeback_packet_t e;
        p            = '0;
        p.is_valid   = 1'b1;
        p.opcode     = opc;
        p.uop_0      = {5'b0, f3};
        p.src_0_a    = addr;
        p.src_1_b    = data;
        p.dest_tag   = tag;
        if (exp_cdb) begin
            e.is_valid = 1'b1;
            e.result   = exp_res;
            e.dest_tag = tag;
            exp_q.push_back(e);
        end
        bus.lsu_req_packet = p;
    endtask

    task automatic wait_accept();
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 30 && !acc; i++) begin
            tick();
            acc = lsu_acc;
        end
        bus.lsu_req_packet = '0;
        check("accept", 32'(acc), 32'd1);
    endtask

    task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input logic [5:0] tag, input bit exp_cdb,
                         input logic [31:0] exp_res);
        drive(opc, f3, addr, data, tag, exp_cdb, exp_res);
        wait_accept();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && (exp_q.size() != 0 || !idle); i++) tick();
        check("done_pending", 32'(exp_q.size()), 32'd0);
        check("done_idle", 32'(idle), 32'd1);
    endtask

    initial begin
        int base;
        n_vec   = 0;
        n_err   = 0;
        cdb_cnt = 0;
        resp_en = 1'b1;
        rst     = 1'b1;
        flush   = 1'b0;
        bus.lsu_req_packet  = '0;
        bus.dmem_req_rdy    = 1'b1;
        bus.dmem_rec_packet = '0;
        bus.cdb_rdy         = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;

        tick();
        tick();
        check("rst_lsu_rdy", 32'(bus.lsu_req_rdy), 32'd0);
        check("rst_req_val", 32'(bus.dmem_req_packet.is_valid), 32'd0);
        check("rst_cdb_val", 32'(bus.cdb_packet.is_valid), 32'd0);
        check("rst_mis_val", 32'(misalign_val), 32'd0);
        check("rst_mis_tag", 32'(misalign_tag), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_lsu_rdy", 32'(bus.lsu_req_rdy), 32'd1);
        check("post_rst_rec_rdy", 32'(bus.dmem_rec_rdy), 32'd1);
        check("post_rst_idle", 32'(idle), 32'd1);
        check("post_rst_req_val", 32'(bus.dmem_req_packet.is_valid), 32'd0);

        // Word store then load.
        cdb_cnt = 0;
        issue(OPC_STORE, 3'b010, 32'h04, 32'hDEADBEEF, 6'd0, 1'b0, 32'h0);
        issue(OPC_LOAD, 3'b010, 32'h04, 32'h0, 6'd5, 1'b1, 32'hDEADBEEF);
        wait_done();
        check("sw_lw_cdb_count", 32'(cdb_cnt), 32'd1);

        // Halfword store, signed halfword and unsigned byte loads.
        cdb_cnt = 0;
        issue(OPC_STORE, 3'b001, 32'h08, 32'hAAAAAAAA, 6'd0, 1'b0, 32'h0);
        issue(OPC_LOAD, 3'b001, 32'h08, 32'h0, 6'd6, 1'b1, 32'hFFFFAAAA);
        issue(OPC_LOAD, 3'b100, 32'h08, 32'h0, 6'd7, 1'b1, 32'h000000AA);
        wait_done();
        check("h_b_cdb_count", 32'(cdb_cnt), 32'd2);

        // Outstanding limit with CDB backpressure.
        cdb_cnt     = 0;
        bus.cdb_rdy = 1'b0;
        resp_en     = 1'b0;
        issue(OPC_LOAD, 3'b010, 32'h04, 32'h0, 6'd1, 1'b1, 32'hDEADBEEF);
        issue(OPC_LOAD, 3'b010, 32'h04, 32'h0, 6'd2, 1'b1, 32'hDEADBEEF);
        drive(OPC_LOAD, 3'b010, 32'h04, 32'h0, 6'd3, 1'b1, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("limit_lsu_rdy", 32'(bus.lsu_req_rdy), 32'd0);
        end
        resp_en = 1'b1;
        wait_accept();
        for (int i = 0; i < 4; i++) tick();
        check("bp_cdb_val", 32'(bus.cdb_packet.is_valid), 32'd1);
        check("bp_cdb_tag", 32'(bus.cdb_packet.dest_tag), 32'd1);
        check("bp_rec_rdy", 32'(bus.dmem_rec_rdy), 32'd0);
        bus.cdb_rdy = 1'b1;
        wait_done();
        check("bp_cdb_count", 32'(cdb_cnt), 32'd3);

        // Misaligned accesses are rejected with a one-cycle pulse.
        req_seen = 1'b0;
        issue(OPC_LOAD, 3'b010, 32'h06, 32'h0, 6'd9, 1'b0, 32'h0);
        check("mis_lw_val", 32'(misalign_val), 32'd1);
        check("mis_lw_tag", 32'(misalign_tag), 32'd9);
        tick();
        check("mis_lw_pulse", 32'(misalign_val), 32'd0);
        issue(OPC_LOAD, 3'b001, 32'h03, 32'h0, 6'd2, 1'b0, 32'h0);
        check("mis_lh_val", 32'(misalign_val), 32'd1);
        check("mis_lh_tag", 32'(misalign_tag), 32'd2);
        tick();
        check("mis_lh_pulse", 32'(misalign_val), 32'd0);
        tick();
        check("mis_no_req", 32'(req_seen), 32'd0);

        // Flush with two loads outstanding.
        resp_en = 1'b0;
        issue(OPC_LOAD, 3'b010, 32'h04, 32'h0, 6'd10, 1'b1, 32'hDEADBEEF);
        issue(OPC_LOAD, 3'b010, 32'h04, 32'h0, 6'd11, 1'b1, 32'hDEADBEEF);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.delete();
        base = cdb_cnt;
        check("drain_lsu_rdy", 32'(bus.lsu_req_rdy), 32'd0);
        check("drain_idle", 32'(idle), 32'd0);
        check("drain_rec_rdy", 32'(bus.dmem_rec_rdy), 32'd1);
        resp_en = 1'b1;
        tick();
        for (int i = 0; i < 20 && !idle; i++) tick();
        check("drain_done_idle", 32'(idle), 32'd1);
        check("drain_resp_left", 32'(resp_q.size()), 32'd0);
        check("drain_no_cdb", 32'(cdb_cnt - base), 32'd0);
        issue(OPC_LOAD, 3'b010, 32'h04, 32'h0, 6'd3, 1'b1, 32'hDEADBEEF);
        wait_done();

        // Reset with REQ full and one load outstanding.
        resp_en = 1'b0;
        issue(OPC_LOAD, 3'b010, 32'h04, 32'h0, 6'd12, 1'b1, 32'hDEADBEEF);
        tick();
        bus.dmem_req_rdy = 1'b0;
        issue(OPC_LOAD, 3'b010, 32'h04, 32'h0, 6'd13, 1'b1, 32'hDEADBEEF);
        check("pre_rst_req_val", 32'(bus.dmem_req_packet.is_valid), 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_req_val", 32'(bus.dmem_req_packet.is_valid), 32'd0);
        check("mid_rst_cdb_val", 32'(bus.cdb_packet.is_valid), 32'd0);
        check("mid_rst_mis_val", 32'(misalign_val), 32'd0);
        check("mid_rst_idle", 32'(idle), 32'd1);
        resp_q.delete();
        exp_q.delete();
        rst              = 1'b0;
        bus.dmem_req_rdy = 1'b1;
        resp_en          = 1'b1;
        tick();
        check("after_rst_idle", 32'(idle), 32'd1);
        check("after_rst_lsu_rdy", 32'(bus.lsu_req_rdy), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_dmem_agent.md
# lsu_dmem_agent

Initiator side of the DMEM request/response protocol: accepts load/store `instruction_t` packets from the LSU issue stage, registers and drives them onto the DMEM request port, and tracks outstanding loads. It collects load responses (`writeback_packet_t`) and forwards them in order to the CDB writeback port. It also filters misaligned accesses and discards stale responses after a flush. It sits between the LSU issue queue and `mem_simple` (or a future cache).

## Interface
- `MAX_OUTSTANDING`, default 2: maximum loads issued to DMEM without a received response (1..7).
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  kill the buffered request and any undelivered load results.
- `lsu_req_rdy`  out  1  block can accept a packet this cycle.
- `lsu_req_packet`  in  instruction_t  request; `is_valid` is the valid bit.
  - `opcode` is `OPC_LOAD` or `OPC_STORE`.
  - `src_0_a.data` is the address.
  - `src_1_b.data` is the store data.
  - `uop_0[2:0]` is funct3.
  - `dest_tag` is the load tag.
- `dmem_req_rdy`  in  1  memory accepts a request.
- `dmem_req_packet`  out  instruction_t  registered request to memory; `is_valid` is the valid bit.
- `dmem_rec_rdy`  out  1  block accepts a memory response.
- `dmem_rec_packet`  in  writeback_packet_t  memory response (`is_valid`, `result`, `dest_tag`).
- `cdb_rdy`  in  1  CDB accepts a writeback.
- `cdb_packet`  out  writeback_packet_t  registered load result to the CDB.
- `misalign_val`  out  1  one-cycle pulse: a misaligned access was rejected.
- `misalign_tag`  out  TAG_WIDTH  `dest_tag` of the rejected access.
- `idle`  out  1  no buffered request, no outstanding load, no pending result.

## Operation
- **Transfer rule.** A transfer on any port occurs at a posedge where the packet's `is_valid` and the matching rdy are both 1.
- **REQ register.** One entry holding the packet driven on `dmem_req_packet`. It passes the input fields through unmodified.
- **lsu_req_rdy.** Asserted when all of the following hold:
  - state is not DRAIN and `flush` is 0;
  - REQ is empty, or REQ fires this cycle;
  - if the incoming packet is a load: `out_cnt` plus loads already in REQ is below `MAX_OUTSTANDING`.
- **Misalignment check.** Applied at acceptance:
  - misaligned means funct3 H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0;
  - a misaligned packet is consumed and never enters REQ;
  - `misalign_val`=1 and `misalign_tag`=its tag on the next cycle only.
- **Stores.** Fire-and-forget; they produce no CDB packet.
- **out_cnt.** Width clog2(MAX_OUTSTANDING+1):
  - +1 when a load fires on DMEM;
  - −1 when a response is accepted;
  - both in the same cycle: unchanged;
  - never wraps.
- **OUT register.** One entry driving `cdb_packet`.
  - `dmem_rec_rdy` = !OUT.valid || `cdb_rdy` (or 1 in DRAIN).
  - An accepted response loads OUT unchanged.
  - OUT clears on a CDB transfer with no new load.
- **State machine.**
  - IDLE → BUSY on any acceptance.
  - BUSY → IDLE when REQ is empty, `out_cnt`=0 and OUT is empty.
  - Any state → DRAIN on `flush` when `drop_cnt`≠0 after the update; otherwise → IDLE.
  - DRAIN → IDLE when `drop_cnt` reaches 0.
- **Flush effects.**
  - REQ cleared; if REQ fires in the flush cycle the load is still counted as issued.
  - OUT cleared.
  - `drop_cnt` set to `out_cnt` after that cycle's updates; `out_cnt` set to 0.
  - A response accepted in the flush cycle is discarded and decrements `drop_cnt`.
- **DRAIN.** Responses are accepted and discarded, `drop_cnt`−1 each; `cdb_packet.is_valid` stays 0.
- **Ordering.** Responses return in request order; the block performs no tag matching.

## Timing
- **Reset values.** While `rst`=1 and on the cycle after its release edge:
  - `dmem_req_packet.is_valid`=0, `cdb_packet.is_valid`=0, `misalign_val`=0, `misalign_tag`=0;
  - all counters 0, state IDLE.
- **Readiness.** `lsu_req_rdy`=0 during `rst`. After reset: `lsu_req_rdy`=1, `dmem_rec_rdy`=1, `idle`=1.
- **Request latency.** Accepted at edge N → `dmem_req_packet.is_valid`=1 in cycle N+1. Back-to-back throughput is one request per cycle while `dmem_req_rdy`=1.
- **Response latency.** Accepted at edge M → `cdb_packet.is_valid`=1 in cycle M+1. One result per cycle with `cdb_rdy` held at 1.
- **Stability.** `dmem_req_packet` and `cdb_packet` hold stable while valid and not ready.
- **Reset priority.** `rst` overrides `flush`; reset mid-operation drops everything with no drain.

## Test plan
- **Word store/load.** SW 0x04←0xDEADBEEF, then LW 0x04 tag 5, with `mem_simple` as responder → exactly one `cdb_packet`: result 0xDEADBEEF, dest_tag 5. No CDB packet for the store.
- **Halfword/byte loads.** SH 0x08←0xAAAAAAAA; LH 0x08 tag 6; LBU 0x08 tag 7 → results in order: 0xFFFFAAAA/6, then 0x000000AA/7.
- **Outstanding limit and CDB backpressure.** `MAX_OUTSTANDING`=2, `cdb_rdy`=0; issue 3 LWs to 0x04.
  - `lsu_req_rdy` is 0 for the third until a response is accepted.
  - Raise `cdb_rdy` → all 3 results (0xDEADBEEF) delivered in tag order, none duplicated.
- **Misaligned accesses.** LW 0x06 tag 9 → `misalign_val`=1 for one cycle with tag 9; `dmem_req_packet.is_valid` never rises. LH 0x03 tag 2 → same behavior.
- **Flush with loads outstanding.** Flush with 2 loads outstanding →
  - state DRAIN, `lsu_req_rdy`=0;
  - both responses accepted and discarded; no CDB packet;
  - then IDLE; next LW 0x04 tag 3 returns 0xDEADBEEF/3.
- **Reset mid-operation.** Assert `rst` with REQ full and one load outstanding → next cycle all valids 0, `idle`=1.
